// File: rtl/mdu_iterative_if.sv
// Handshake and operand/result bundle for the iterative multiply/divide unit.
//   start, op, a, b, flush : requester -> unit (master drives)
//   busy, done, dz, hi, lo : unit -> requester (slave drives)
interface mdu_iterative_if #(
    parameter int unsigned W = 32
) ();
    logic         start;
    logic [1:0]   op;
    logic [W-1:0] a;
    logic [W-1:0] b;
    logic         flush;
    logic         busy;
    logic         done;
    logic         dz;
    logic [W-1:0] hi;
    logic [W-1:0] lo;

    modport master (
        output start, op, a, b, flush,
        input  busy, done, dz, hi, lo
    );

    modport slave (
        input  start, op, a, b, flush,
        output busy, done, dz, hi, lo
    );
endinterface

// File: rtl/mdu_iterative.sv
// Multi-cycle multiply/divide unit (MULTU/MULT/DIVU/DIV) for the execute stage.
// Shift-add multiply and restoring divide on operand magnitudes, one bit per cycle,
// with a final sign-fix cycle. Results land in HI/LO registers.
//   CLK  : clock, rising edge
//   nRST : synchronous active-low reset
//   bus  : slave side of mdu_iterative_if
//          start/op/a/b/flush in; busy/done/dz/hi/lo out
module mdu_iterative #(
    parameter int unsigned W    = 32,
    parameter int unsigned CNTW = $clog2(W) + 1
) (
    input logic            CLK,
    input logic            nRST,
    mdu_iterative_if.slave bus
);

    typedef enum logic [1:0] {StIdle, StCalc, StFix, StDone} state_e;

    state_e          state_q, state_d;
    logic [CNTW-1:0] cnt_q, cnt_d;
    logic [2*W-1:0]  acc_q, acc_d;   // mult: {partial, multiplier}; div: {remainder, dividend/quotient}
    logic [W-1:0]    dvs_q, dvs_d;   // |b|: multiplicand addend or divisor
    logic [1:0]      op_q, op_d;
    logic            neg_q, neg_d;   // result (product/quotient) must be negated
    logic            sa_q, sa_d;     // sign of a, for the remainder
    logic [W-1:0]    hi_q, hi_d;
    logic [W-1:0]    lo_q, lo_d;
    logic            dz_q, dz_d;

    logic           signed_op;
    logic [W-1:0]   mag_a, mag_b;
    logic [W:0]     mul_sum;
    logic [2*W-1:0] mul_next;
    logic [W:0]     rem_sh;
    logic [W+1:0]   div_diff;
    logic [2*W-1:0] div_next;
    logic [2*W-1:0] prod_neg;
    logic           unused_diff_bit;

    assign signed_op = bus.op[0];
    assign mag_a     = (signed_op && bus.a[W-1]) ? -bus.a : bus.a;
    assign mag_b     = (signed_op && bus.b[W-1]) ? -bus.b : bus.b;

    // Multiply step: add multiplicand into the upper half when the LSB is set, then shift right.
    assign mul_sum  = {1'b0, acc_q[2*W-1:W]} + (acc_q[0] ? {1'b0, dvs_q} : {(W+1){1'b0}});
    assign mul_next = {mul_sum, acc_q[W-1:1]};

    // Restoring divide step: shift in the next dividend bit, keep the difference if no borrow.
    assign rem_sh   = {acc_q[2*W-1:W], acc_q[W-1]};
    assign div_diff = {1'b0, rem_sh} - {2'b00, dvs_q};
    assign div_next = div_diff[W+1] ? {rem_sh[W-1:0], acc_q[W-2:0], 1'b0}
                                    : {div_diff[W-1:0], acc_q[W-2:0], 1'b1};
    // Without a borrow the difference is below the divisor, so bit W is always zero.
    assign unused_diff_bit = div_diff[W];

    assign prod_neg = -acc_q;

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        acc_d   = acc_q;
        dvs_d   = dvs_q;
        op_d    = op_q;
        neg_d   = neg_q;
        sa_d    = sa_q;
        hi_d    = hi_q;
        lo_d    = lo_q;
        dz_d    = dz_q;

        if (bus.flush) begin
            state_d = StIdle;
        end else begin
            unique case (state_q)
                StIdle, StDone: begin
                    if (bus.start) begin
                        if (bus.op[1] && (bus.b == '0)) begin
                            // Divide by zero bypasses the iteration entirely.
                            state_d = StDone;
                            hi_d    = bus.a;
                            lo_d    = '1;
                            dz_d    = 1'b1;
                        end else begin
                            state_d = StCalc;
                            cnt_d   = CNTW'(W);
                            acc_d   = {{W{1'b0}}, mag_a};
                            dvs_d   = mag_b;
                            op_d    = bus.op;
                            neg_d   = signed_op && (bus.a[W-1] ^ bus.b[W-1]);
                            sa_d    = signed_op && bus.a[W-1];
                            dz_d    = 1'b0;
                        end
                    end else begin
                        state_d = StIdle;
                    end
                end
                StCalc: begin
                    acc_d = op_q[1] ? div_next : mul_next;
                    cnt_d = cnt_q - CNTW'(1);
                    if (cnt_q == CNTW'(1)) begin
                        state_d = StFix;
                    end
                end
                StFix: begin
                    if (op_q[1]) begin
                        lo_d = neg_q ? prod_neg[W-1:0] : acc_q[W-1:0];
                        hi_d = sa_q ? -acc_q[2*W-1:W] : acc_q[2*W-1:W];
                    end else begin
                        {hi_d, lo_d} = neg_q ? prod_neg : acc_q;
                    end
                    state_d = StDone;
                end
                default: state_d = StIdle;
            endcase
        end
    end

    always_ff @(posedge CLK) begin
        if (!nRST) begin
            state_q <= StIdle;
            cnt_q   <= '0;
            acc_q   <= '0;
            dvs_q   <= '0;
            op_q    <= '0;
            neg_q   <= 1'b0;
            sa_q    <= 1'b0;
            hi_q    <= '0;
            lo_q    <= '0;
            dz_q    <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            acc_q   <= acc_d;
            dvs_q   <= dvs_d;
            op_q    <= op_d;
            neg_q   <= neg_d;
            sa_q    <= sa_d;
            hi_q    <= hi_d;
            lo_q    <= lo_d;
            dz_q    <= dz_d;
        end
    end

    assign bus.busy = (state_q == StCalc) || (state_q == StFix);
    assign bus.done = (state_q == StDone);
    assign bus.hi   = hi_q;
    assign bus.lo   = lo_q;
    assign bus.dz   = dz_q;

endmodule

// File: tb/tb_mdu_iterative.sv
// Self-checking bench for mdu_iterative (W=32): a cycle-level behavioural model computes
// results with native 64-bit arithmetic and tracks only "cycles until done"; a compare
// process checks every output each cycle, and directed cases pin literal results.
module tb_mdu_iterative;
    localparam int unsigned W = 32;

    logic CLK;
    logic nRST;
    int   n_assert = 0;
    int   n_fail   = 0;
    bit   check_en = 0;

    mdu_iterative_if #(.W(W)) bus ();

    mdu_iterative #(.W(W)) dut (
        .CLK  (CLK),
        .nRST (nRST),
        .bus  (bus)
    );

    initial CLK = 0;
    always #5 CLK = ~CLK;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_assert++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Reference results from plain arithmetic.
    function automatic void model_result(input logic [1:0] o, input logic [31:0] x,
                                         input logic [31:0] y, output logic [31:0] h,
                                         output logic [31:0] l);
        logic [63:0] p;
        longint      sx, sy, sq, sr;
        sx = $signed(x);
        sy = $signed(y);
        case (o)
            2'b00: begin p = {32'd0, x} * {32'd0, y}; h = p[63:32]; l = p[31:0]; end
            2'b01: begin p = sx * sy; h = p[63:32]; l = p[31:0]; end
            2'b10: begin l = x / y; h = x % y; end
            default: begin
                sq = sx / sy;
                sr = sx % sy;
                p  = sq;
                l  = p[31:0];
                p  = sr;
                h  = p[31:0];
            end
        endcase
    endfunction

    // Model state: cycles left in the busy window and the visible result registers.
    int          m_cnt = 0;
    bit          m_done = 0;
    bit          m_dz = 0;
    logic [31:0] m_hi = 0, m_lo = 0, p_hi = 0, p_lo = 0;

    always @(posedge CLK) begin
        if (!nRST) begin
            m_cnt = 0; m_done = 0; m_dz = 0; m_hi = 0; m_lo = 0;
        end else if (bus.flush) begin
            m_cnt = 0; m_done = 0;
        end else if (m_cnt != 0) begin
            m_cnt--;
            m_done = (m_cnt == 0);
            if (m_cnt == 0) begin m_hi = p_hi; m_lo = p_lo; end
        end else if (bus.start) begin
            if (bus.op[1] && bus.b == 0) begin
                m_done = 1; m_hi = bus.a; m_lo = '1; m_dz = 1;
            end else begin
                model_result(bus.op, bus.a, bus.b, p_hi, p_lo);
                m_cnt = W + 1; m_done = 0; m_dz = 0;
            end
        end else begin
            m_done = 0;
        end
    end

    always @(negedge CLK) begin
        if (check_en) begin
            chk("busy", 64'(bus.busy), 64'(m_cnt != 0));
            chk("done", 64'(bus.done), 64'(m_done));
            chk("dz",   64'(bus.dz),   64'(m_dz));
            chk("hi",   64'(bus.hi),   64'(m_hi));
            chk("lo",   64'(bus.lo),   64'(m_lo));
        end
    end

    task automatic tick();
        @(posedge CLK);
        #1;
    endtask

    // Issue one op, return latency (cycles from accept edge to the done cycle) and busy count.
    // Returns at the negedge of the done cycle; lat=61 means done never came.
    task automatic run_op(input logic [1:0] o, input logic [31:0] x, input logic [31:0] y,
                          output int lat, output int bc);
        bus.start = 1; bus.op = o; bus.a = x; bus.b = y;
        tick();
        bus.start = 0;
        bc  = 0;
        lat = 61;
        for (int i = 1; i <= 60; i++) begin
            @(negedge CLK);
            if (bus.busy) bc++;
            if (bus.done) begin lat = i; break; end
        end
    endtask

    function automatic logic [31:0] rand_val();
        case ($urandom_range(0, 7))
            0: return 32'h0;
            1: return 32'h8000_0000;
            2: return 32'hFFFF_FFFF;
            3: return 32'($urandom_range(0, 15));
            default: return $urandom;
        endcase
    endfunction

    initial begin
        int lat, bc, seen;
        nRST = 0; bus.start = 0; bus.op = 0; bus.a = 0; bus.b = 0; bus.flush = 0;
        tick();
        check_en = 1;
        tick();
        nRST = 1;
        @(negedge CLK);
        chk("rst_busy", 64'(bus.busy), 0);
        chk("rst_done", 64'(bus.done), 0);
        chk("rst_dz",   64'(bus.dz), 0);
        chk("rst_hi",   64'(bus.hi), 0);
        chk("rst_lo",   64'(bus.lo), 0);

        run_op(2'b00, 32'hFFFF_FFFF, 32'hFFFF_FFFF, lat, bc);
        chk("multu_lat", 64'(lat), 34);
        chk("multu_busy_cycles", 64'(bc), 33);
        chk("multu_hi", 64'(bus.hi), 64'hFFFF_FFFE);
        chk("multu_lo", 64'(bus.lo), 64'h1);
        tick();

        run_op(2'b01, 32'hFFFF_FFFD, 32'd7, lat, bc);
        chk("mult_lat", 64'(lat), 34);
        chk("mult_hi", 64'(bus.hi), 64'hFFFF_FFFF);
        chk("mult_lo", 64'(bus.lo), 64'hFFFF_FFEB);
        tick();

        run_op(2'b11, 32'hFFFF_FFF9, 32'd2, lat, bc);
        chk("div_lat", 64'(lat), 34);
        chk("div_lo", 64'(bus.lo), 64'hFFFF_FFFD);
        chk("div_hi", 64'(bus.hi), 64'hFFFF_FFFF);
        tick();

        run_op(2'b10, 32'd100, 32'd0, lat, bc);
        chk("dz_lat", 64'(lat), 1);
        chk("dz_busy_cycles", 64'(bc), 0);
        chk("dz_flag", 64'(bus.dz), 1);
        chk("dz_hi", 64'(bus.hi), 64'd100);
        chk("dz_lo", 64'(bus.lo), 64'hFFFF_FFFF);
        tick();

        run_op(2'b11, 32'h8000_0000, 32'hFFFF_FFFF, lat, bc);
        chk("divovf_dz_cleared", 64'(bus.dz), 0);
        chk("divovf_lo", 64'(bus.lo), 64'h8000_0000);
        chk("divovf_hi", 64'(bus.hi), 0);
        tick();

        run_op(2'b10, 32'h8000_0000, 32'd3, lat, bc);
        chk("divu_lo", 64'(bus.lo), 64'h2AAA_AAAA);
        chk("divu_hi", 64'(bus.hi), 64'd2);
        tick();

        // Flush mid-divide, with an ignored start pulse while busy.
        run_op(2'b00, 32'd5, 32'd6, lat, bc);
        chk("mul56_lo", 64'(bus.lo), 64'd30);
        chk("mul56_hi", 64'(bus.hi), 0);
        tick();
        bus.start = 1; bus.op = 2'b10; bus.a = 32'd9; bus.b = 32'd2;
        tick();                                     // E0
        bus.start = 0;
        repeat (2) tick();
        bus.start = 1; bus.op = 2'b00; bus.a = 32'd7; bus.b = 32'd7;
        tick();                                     // E0+3, ignored
        bus.start = 0;
        repeat (6) tick();
        bus.flush = 1;
        tick();                                     // E0+10
        bus.flush = 0;
        @(negedge CLK);
        chk("flush_busy", 64'(bus.busy), 0);
        chk("flush_done", 64'(bus.done), 0);
        seen = 0;
        for (int i = 0; i < 40; i++) begin
            @(negedge CLK);
            if (bus.done) seen++;
        end
        chk("flush_no_done", 64'(seen), 0);
        chk("flush_hi_kept", 64'(bus.hi), 0);
        chk("flush_lo_kept", 64'(bus.lo), 64'd30);
        tick();

        // Reset in the middle of a MULT.
        bus.start = 1; bus.op = 2'b01; bus.a = 32'hFFFF_FFFD; bus.b = 32'd7;
        tick();                                     // E0
        bus.start = 0;
        repeat (4) tick();
        nRST = 0;
        tick();                                     // E0+5
        nRST = 1;
        @(negedge CLK);
        chk("midrst_busy", 64'(bus.busy), 0);
        chk("midrst_done", 64'(bus.done), 0);
        chk("midrst_hi", 64'(bus.hi), 0);
        chk("midrst_lo", 64'(bus.lo), 0);
        tick();

        // Back-to-back: second start presented during the DONE cycle.
        run_op(2'b00, 32'd5, 32'd6, lat, bc);
        run_op(2'b10, 32'd100, 32'd7, lat, bc);
        chk("b2b_lat", 64'(lat), 34);
        chk("b2b_lo", 64'(bus.lo), 64'd14);
        chk("b2b_hi", 64'(bus.hi), 64'd2);
        tick();
        tick();

        // Randomized traffic; the compare process checks every cycle.
        for (int i = 0; i < 4000; i++) begin
            bus.start = ($urandom_range(0, 3) == 0);
            bus.op    = 2'($urandom_range(0, 3));
            bus.a     = rand_val();
            bus.b     = rand_val();
            bus.flush = ($urandom_range(0, 99) == 0);
            nRST      = !($urandom_range(0, 799) == 0);
            tick();
        end
        bus.start = 0; bus.flush = 0; nRST = 1;
        repeat (40) tick();

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end
endmodule
